// File: rtl/bcd_calendar.sv
// BCD time-of-day / calendar counter with day-of-week, validated atomic load and rollover strobes.
// Define BCD_CALENDAR_LEAP_YEAR_EN to enable 29 February in leap years; otherwise February always has 28 days.
module bcd_calendar #(
  parameter int YEAR_DIGITS = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     inc_i,
  input  logic                     load_i,
  input  logic [4*YEAR_DIGITS-1:0] load_year_i,
  input  logic [4:0]               load_month_i,
  input  logic [5:0]               load_day_i,
  input  logic [5:0]               load_hour_i,
  input  logic [6:0]               load_minute_i,
  input  logic [6:0]               load_second_i,
  input  logic [2:0]               load_dow_i,
  output logic [4*YEAR_DIGITS-1:0] year_o,
  output logic [4:0]               month_o,
  output logic [5:0]               day_o,
  output logic [5:0]               hour_o,
  output logic [6:0]               minute_o,
  output logic [6:0]               second_o,
  output logic [2:0]               dow_o,
  output logic                     valid_o,
  output logic                     load_err_o,
  output logic                     minute_tick_o,
  output logic                     day_tick_o
);

  localparam int YW = 4 * YEAR_DIGITS;

  logic [YW-1:0] year_q, year_d, year_inc;
  logic [4:0]    month_q, month_d;
  logic [5:0]    day_q, day_d, hour_q, hour_d;
  logic [6:0]    minute_q, minute_d, second_q, second_d;
  logic [2:0]    dow_q, dow_d;
  logic          valid_q, valid_d, load_err_q, load_err_d;
  logic          minute_tick_q, minute_tick_d, day_tick_q, day_tick_d;
  logic          leap_cur, leap_ld, load_ok;
  logic [YEAR_DIGITS-1:0] ydig_ok, ycarry;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [5:0] days_in_month(input logic [4:0] m, input logic leap);
    case (m)
      5'h04, 5'h06, 5'h09, 5'h11: return 6'h30;
      5'h02:                      return leap ? 6'h29 : 6'h28;
      default:                    return 6'h31;
    endcase
  endfunction

`ifdef BCD_CALENDAR_LEAP_YEAR_EN
  // A two-digit BCD number 10t+o is divisible by 4 iff o is 0/4/8 (t even) or 2/6 (t odd).
  function automatic logic div4(input logic [7:0] v);
    if (v[4]) return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
    return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
  endfunction

  function automatic logic is_leap(input logic [15:0] y);
    if (YEAR_DIGITS == 4 && y[7:0] == 8'h00) return div4(y[15:8]);
    return div4(y[7:0]);
  endfunction

  assign leap_cur = is_leap(16'(year_q));
  assign leap_ld  = is_leap(16'(load_year_i));
`else
  assign leap_cur = 1'b0;
  assign leap_ld  = 1'b0;
`endif

  for (genvar gi = 0; gi < YEAR_DIGITS; gi++) begin : g_year
    assign ydig_ok[gi] = load_year_i[4*gi +: 4] <= 4'd9;
    if (gi == 0) begin : g_c0
      assign ycarry[gi] = 1'b1;
    end else begin : g_cn
      assign ycarry[gi] = ycarry[gi-1] && (year_q[4*(gi-1) +: 4] == 4'd9);
    end
    assign year_inc[4*gi +: 4] = !ycarry[gi]                  ? year_q[4*gi +: 4] :
                                 (year_q[4*gi +: 4] == 4'd9) ? 4'd0 :
                                                               year_q[4*gi +: 4] + 4'd1;
  end

  assign load_ok = (&ydig_ok)
                && (load_month_i[3:0] <= 4'd9)
                && (load_month_i[4] ? (load_month_i[3:0] <= 4'd2) : (load_month_i[3:0] != 4'd0))
                && (load_day_i[3:0] <= 4'd9) && (load_day_i != 6'h00)
                && (load_day_i <= days_in_month(load_month_i, leap_ld))
                && (load_hour_i[3:0] <= 4'd9) && (load_hour_i <= 6'h23)
                && (load_minute_i[3:0] <= 4'd9) && (load_minute_i <= 7'h59)
                && (load_second_i[3:0] <= 4'd9) && (load_second_i <= 7'h59)
                && (load_dow_i <= 3'd6);

  always_comb begin
    year_d        = year_q;
    month_d       = month_q;
    day_d         = day_q;
    hour_d        = hour_q;
    minute_d      = minute_q;
    second_d      = second_q;
    dow_d         = dow_q;
    valid_d       = valid_q;
    load_err_d    = 1'b0;
    minute_tick_d = 1'b0;
    day_tick_d    = 1'b0;
    // Load has priority over inc, and a rejected load still swallows the increment.
    if (load_i) begin
      if (load_ok) begin
        year_d   = load_year_i;
        month_d  = load_month_i;
        day_d    = load_day_i;
        hour_d   = load_hour_i;
        minute_d = load_minute_i;
        second_d = load_second_i;
        dow_d    = load_dow_i;
        valid_d  = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (inc_i) begin
      second_d = (second_q == 7'h59) ? 7'h00 : 7'(bcd_inc({1'b0, second_q}));
      if (second_q == 7'h59) begin
        minute_tick_d = 1'b1;
        minute_d = (minute_q == 7'h59) ? 7'h00 : 7'(bcd_inc({1'b0, minute_q}));
        if (minute_q == 7'h59) begin
          hour_d = (hour_q == 6'h23) ? 6'h00 : 6'(bcd_inc({2'b00, hour_q}));
          if (hour_q == 6'h23) begin
            day_tick_d = 1'b1;
            dow_d = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
            if (day_q == days_in_month(month_q, leap_cur)) begin
              day_d   = 6'h01;
              month_d = (month_q == 5'h12) ? 5'h01 : 5'(bcd_inc({3'b000, month_q}));
              if (month_q == 5'h12) year_d = year_inc;
            end else begin
              day_d = 6'(bcd_inc({2'b00, day_q}));
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      year_q        <= '0;
      month_q       <= 5'h01;
      day_q         <= 6'h01;
      hour_q        <= 6'h00;
      minute_q      <= 7'h00;
      second_q      <= 7'h00;
      dow_q         <= 3'd6;
      valid_q       <= 1'b0;
      load_err_q    <= 1'b0;
      minute_tick_q <= 1'b0;
      day_tick_q    <= 1'b0;
    end else begin
      year_q        <= year_d;
      month_q       <= month_d;
      day_q         <= day_d;
      hour_q        <= hour_d;
      minute_q      <= minute_d;
      second_q      <= second_d;
      dow_q         <= dow_d;
      valid_q       <= valid_d;
      load_err_q    <= load_err_d;
      minute_tick_q <= minute_tick_d;
      day_tick_q    <= day_tick_d;
    end
  end

  assign year_o        = year_q;
  assign month_o       = month_q;
  assign day_o         = day_q;
  assign hour_o        = hour_q;
  assign minute_o      = minute_q;
  assign second_o      = second_q;
  assign dow_o         = dow_q;
  assign valid_o       = valid_q;
  assign load_err_o    = load_err_q;
  assign minute_tick_o = minute_tick_q;
  assign day_tick_o    = day_tick_q;

endmodule

// File: tb/tb_bcd_calendar.sv
// Bench for bcd_calendar: 2-digit and 4-digit year instances share stimulus and are checked
// against an integer calendar model, plus a directed vector table and corner sequences.
module tb_bcd_calendar;

  logic        clk = 1'b0;
  logic        rst_n, inc, load;
  logic [15:0] ly;
  logic [4:0]  lmo;
  logic [5:0]  ld, lh;
  logic [6:0]  lmi, ls;
  logic [2:0]  ldow;

  logic [7:0]  y2;
  logic [15:0] y4;
  logic [4:0]  mo2, mo4;
  logic [5:0]  d2, d4, h2, h4;
  logic [6:0]  mi2, mi4, s2, s4;
  logic [2:0]  dw2, dw4;
  logic        v2, v4, err2, err4, mt2, mt4, dt2, dt4;

  int checks = 0;
  int failures = 0;

  int my[2], mmo[2], md[2], mh[2], mmi[2], ms[2], mdw[2];
  bit mv[2], merr[2], mmt[2], mdt[2];

  always #5 clk = ~clk;

  bcd_calendar #(.YEAR_DIGITS(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .inc_i(inc), .load_i(load),
    .load_year_i(ly[7:0]), .load_month_i(lmo), .load_day_i(ld), .load_hour_i(lh),
    .load_minute_i(lmi), .load_second_i(ls), .load_dow_i(ldow),
    .year_o(y2), .month_o(mo2), .day_o(d2), .hour_o(h2), .minute_o(mi2), .second_o(s2),
    .dow_o(dw2), .valid_o(v2), .load_err_o(err2), .minute_tick_o(mt2), .day_tick_o(dt2));

  bcd_calendar #(.YEAR_DIGITS(4)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .inc_i(inc), .load_i(load),
    .load_year_i(ly), .load_month_i(lmo), .load_day_i(ld), .load_hour_i(lh),
    .load_minute_i(lmi), .load_second_i(ls), .load_dow_i(ldow),
    .year_o(y4), .month_o(mo4), .day_o(d4), .hour_o(h4), .minute_o(mi4), .second_o(s4),
    .dow_o(dw4), .valid_o(v4), .load_err_o(err4), .minute_tick_o(mt4), .day_tick_o(dt4));

  typedef struct {
    bit ld, in;
    logic [15:0] y; logic [4:0] mo; logic [5:0] d, h; logic [6:0] mi, s; logic [2:0] dw;
    logic [7:0] ey; logic [4:0] emo; logic [5:0] ed, eh; logic [6:0] emi, es; logic [2:0] edw;
    bit ev, eerr, emt, edt;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  // k=0: two-digit year (00 always leap); k=1: Gregorian four-digit year.
  function automatic int dim_m(input int mo, input int y, input int k);
    bit lp;
`ifdef BCD_CALENDAR_LEAP_YEAR_EN
    lp = (k == 0) ? (y % 4 == 0) : ((y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0)));
`else
    lp = 1'b0;
`endif
    case (mo)
      4, 6, 9, 11: return 30;
      2:           return lp ? 29 : 28;
      default:     return 31;
    endcase
  endfunction

  task automatic model_edge();
    logic [15:0] yv;
    bit ok;
    int ty, tmo, td, th, tmi, ts;
    for (int k = 0; k < 2; k++) begin
      merr[k] = 0; mmt[k] = 0; mdt[k] = 0;
      if (!rst_n) begin
        my[k] = 0; mmo[k] = 1; md[k] = 1; mh[k] = 0; mmi[k] = 0; ms[k] = 0; mdw[k] = 6; mv[k] = 0;
      end else if (load) begin
        yv = (k == 0) ? {8'h00, ly[7:0]} : ly;
        ok = 1;
        for (int n = 0; n < 4; n++) if (yv[4*n +: 4] > 4'd9) ok = 0;
        if (lmo[3:0] > 4'd9 || ld[3:0] > 4'd9 || lh[3:0] > 4'd9 || lmi[3:0] > 4'd9 || ls[3:0] > 4'd9) ok = 0;
        ty = bcd2int(yv); tmo = bcd2int(16'(lmo)); td = bcd2int(16'(ld));
        th = bcd2int(16'(lh)); tmi = bcd2int(16'(lmi)); ts = bcd2int(16'(ls));
        if (tmo < 1 || tmo > 12) ok = 0;
        else if (td < 1 || td > dim_m(tmo, ty, k)) ok = 0;
        if (th > 23 || tmi > 59 || ts > 59 || ldow > 3'd6) ok = 0;
        if (ok) begin
          my[k] = ty; mmo[k] = tmo; md[k] = td; mh[k] = th; mmi[k] = tmi; ms[k] = ts;
          mdw[k] = int'(ldow); mv[k] = 1;
        end else merr[k] = 1;
      end else if (inc) begin
        ms[k]++;
        if (ms[k] == 60) begin
          ms[k] = 0; mmt[k] = 1; mmi[k]++;
          if (mmi[k] == 60) begin
            mmi[k] = 0; mh[k]++;
            if (mh[k] == 24) begin
              mh[k] = 0; mdt[k] = 1; mdw[k] = (mdw[k] + 1) % 7; md[k]++;
              if (md[k] > dim_m(mmo[k], my[k], k)) begin
                md[k] = 1; mmo[k]++;
                if (mmo[k] > 12) begin
                  mmo[k] = 1;
                  my[k] = (my[k] + 1) % ((k == 0) ? 100 : 10000);
                end
              end
            end
          end
        end
      end
    end
  endtask

  task automatic cmp_model();
    chk("m2.year", 32'(y2), 32'(to_bcd(my[0])));   chk("m4.year", 32'(y4), 32'(to_bcd(my[1])));
    chk("m2.month", 32'(mo2), 32'(to_bcd(mmo[0]))); chk("m4.month", 32'(mo4), 32'(to_bcd(mmo[1])));
    chk("m2.day", 32'(d2), 32'(to_bcd(md[0])));     chk("m4.day", 32'(d4), 32'(to_bcd(md[1])));
    chk("m2.hour", 32'(h2), 32'(to_bcd(mh[0])));    chk("m4.hour", 32'(h4), 32'(to_bcd(mh[1])));
    chk("m2.min", 32'(mi2), 32'(to_bcd(mmi[0])));   chk("m4.min", 32'(mi4), 32'(to_bcd(mmi[1])));
    chk("m2.sec", 32'(s2), 32'(to_bcd(ms[0])));     chk("m4.sec", 32'(s4), 32'(to_bcd(ms[1])));
    chk("m2.dow", 32'(dw2), 32'(mdw[0]));           chk("m4.dow", 32'(dw4), 32'(mdw[1]));
    chk("m2.valid", 32'(v2), 32'(mv[0]));           chk("m4.valid", 32'(v4), 32'(mv[1]));
    chk("m2.err", 32'(err2), 32'(merr[0]));         chk("m4.err", 32'(err4), 32'(merr[1]));
    chk("m2.mtick", 32'(mt2), 32'(mmt[0]));         chk("m4.mtick", 32'(mt4), 32'(mmt[1]));
    chk("m2.dtick", 32'(dt2), 32'(mdt[0]));         chk("m4.dtick", 32'(dt4), 32'(mdt[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    cmp_model();
    $display("txn rst_n=%b ld=%b inc=%b -> %h-%h-%h %h:%h:%h dow=%0d v=%b err=%b mt=%b dt=%b (y2=%h)",
             rst_n, load, inc, y4, mo4, d4, h4, mi4, s4, dw4, v4, err4, mt4, dt4, y2);
  endtask

  task automatic set_load(input logic [15:0] y, input logic [4:0] mo, input logic [5:0] d,
                          input logic [5:0] h, input logic [6:0] mi, input logic [6:0] s,
                          input logic [2:0] dw);
    ly = y; lmo = mo; ld = d; lh = h; lmi = mi; ls = s; ldow = dw;
  endtask

  initial begin
    int mt_count;
    int yy, mo, dd, hh, mi, ss, dw;

    vt[0]  = '{1'b0, 1'b1, 16'h0000, 5'h00, 6'h00, 6'h00, 7'h00, 7'h00, 3'd0,
               8'h00, 5'h01, 6'h01, 6'h00, 7'h00, 7'h01, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 16'h2099, 5'h12, 6'h31, 6'h23, 7'h59, 7'h59, 3'd5,
               8'h99, 5'h12, 6'h31, 6'h23, 7'h59, 7'h59, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 16'h0000, 5'h00, 6'h00, 6'h00, 7'h00, 7'h00, 3'd0,
               8'h00, 5'h01, 6'h01, 6'h00, 7'h00, 7'h00, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 16'h0000, 5'h00, 6'h00, 6'h00, 7'h00, 7'h00, 3'd0,
               8'h00, 5'h01, 6'h01, 6'h00, 7'h00, 7'h00, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 16'h2024, 5'h13, 6'h01, 6'h10, 7'h10, 7'h10, 3'd1,
               8'h00, 5'h01, 6'h01, 6'h00, 7'h00, 7'h00, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 16'h2024, 5'h04, 6'h31, 6'h10, 7'h10, 7'h10, 3'd1,
               8'h00, 5'h01, 6'h01, 6'h00, 7'h00, 7'h00, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 16'h2024, 5'h05, 6'h05, 6'h10, 7'h5A, 7'h10, 3'd1,
               8'h00, 5'h01, 6'h01, 6'h00, 7'h00, 7'h00, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 16'h2024, 5'h05, 6'h05, 6'h10, 7'h10, 7'h10, 3'd7,
               8'h00, 5'h01, 6'h01, 6'h00, 7'h00, 7'h00, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 16'h2024, 5'h02, 6'h28, 6'h23, 7'h59, 7'h59, 3'd3,
               8'h24, 5'h02, 6'h28, 6'h23, 7'h59, 7'h59, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef BCD_CALENDAR_LEAP_YEAR_EN
    vt[9]  = '{1'b0, 1'b1, 16'h0000, 5'h00, 6'h00, 6'h00, 7'h00, 7'h00, 3'd0,
               8'h24, 5'h02, 6'h29, 6'h00, 7'h00, 7'h00, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[10] = '{1'b1, 1'b0, 16'h2024, 5'h02, 6'h29, 6'h23, 7'h59, 7'h59, 3'd4,
               8'h24, 5'h02, 6'h29, 6'h23, 7'h59, 7'h59, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 16'h0000, 5'h00, 6'h00, 6'h00, 7'h00, 7'h00, 3'd0,
               8'h24, 5'h03, 6'h01, 6'h00, 7'h00, 7'h00, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1};
`else
    vt[9]  = '{1'b0, 1'b1, 16'h0000, 5'h00, 6'h00, 6'h00, 7'h00, 7'h00, 3'd0,
               8'h24, 5'h03, 6'h01, 6'h00, 7'h00, 7'h00, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[10] = '{1'b1, 1'b0, 16'h2024, 5'h02, 6'h29, 6'h23, 7'h59, 7'h59, 3'd4,
               8'h24, 5'h03, 6'h01, 6'h00, 7'h00, 7'h00, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 16'h0000, 5'h00, 6'h00, 6'h00, 7'h00, 7'h00, 3'd0,
               8'h24, 5'h03, 6'h01, 6'h00, 7'h00, 7'h01, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    vt[12] = '{1'b1, 1'b1, 16'h2024, 5'h06, 6'h15, 6'h12, 7'h00, 7'h00, 3'd6,
               8'h24, 5'h06, 6'h15, 6'h12, 7'h00, 7'h00, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b1, 16'h2024, 5'h06, 6'h15, 6'h24, 7'h00, 7'h00, 3'd6,
               8'h24, 5'h06, 6'h15, 6'h12, 7'h00, 7'h00, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b1, 16'h0000, 5'h00, 6'h00, 6'h00, 7'h00, 7'h00, 3'd0,
               8'h24, 5'h06, 6'h15, 6'h12, 7'h00, 7'h01, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; inc = 1'b0; load = 1'b0;
    set_load(16'h0000, 5'h00, 6'h00, 6'h00, 7'h00, 7'h00, 3'd0);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Reset state against literal values.
    chk("rst.year", 32'(y4), 32'h0000);  chk("rst.month", 32'(mo2), 32'h01);
    chk("rst.day", 32'(d2), 32'h01);     chk("rst.time", {8'h0, 2'b0, h2, 1'b0, mi2, 1'b0, s2}, 32'h0);
    chk("rst.dow", 32'(dw2), 32'd6);     chk("rst.valid", 32'(v2), 32'd0);
    chk("rst.pulses", {29'b0, err2, mt2, dt2}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      load = vt[i].ld; inc = vt[i].in;
      set_load(vt[i].y, vt[i].mo, vt[i].d, vt[i].h, vt[i].mi, vt[i].s, vt[i].dw);
      cycle();
      chk($sformatf("tbl%0d.year", i), 32'(y2), 32'(vt[i].ey));
      chk($sformatf("tbl%0d.month", i), 32'(mo2), 32'(vt[i].emo));
      chk($sformatf("tbl%0d.day", i), 32'(d2), 32'(vt[i].ed));
      chk($sformatf("tbl%0d.hour", i), 32'(h2), 32'(vt[i].eh));
      chk($sformatf("tbl%0d.min", i), 32'(mi2), 32'(vt[i].emi));
      chk($sformatf("tbl%0d.sec", i), 32'(s2), 32'(vt[i].es));
      chk($sformatf("tbl%0d.dow", i), 32'(dw2), 32'(vt[i].edw));
      chk($sformatf("tbl%0d.flags", i), {28'b0, v2, err2, mt2, dt2},
          {28'b0, vt[i].ev, vt[i].eerr, vt[i].emt, vt[i].edt});
    end
    load = 1'b0; inc = 1'b0;

    // 2100 is not a Gregorian leap year; its two-digit alias 00 is.
    load = 1'b1;
    set_load(16'h2100, 5'h02, 6'h28, 6'h23, 7'h59, 7'h59, 3'd0);
    cycle();
    load = 1'b0; inc = 1'b1;
    cycle();
    inc = 1'b0;
    chk("c2100.year4", 32'(y4), 32'h2100);
    chk("c2100.md4", {16'b0, 3'b0, mo4, 2'b0, d4}, 32'h0000_0301);
`ifdef BCD_CALENDAR_LEAP_YEAR_EN
    chk("c2100.md2", {16'b0, 3'b0, mo2, 2'b0, d2}, 32'h0000_0229);
`else
    chk("c2100.md2", {16'b0, 3'b0, mo2, 2'b0, d2}, 32'h0000_0301);
`endif

    load = 1'b1;
    set_load(16'h9999, 5'h12, 6'h31, 6'h23, 7'h59, 7'h59, 3'd3);
    cycle();
    load = 1'b0; inc = 1'b1;
    cycle();
    inc = 1'b0;
    chk("c9999.year4", 32'(y4), 32'h0000);
    chk("c9999.year2", 32'(y2), 32'h00);
    chk("c9999.dtick", {30'b0, dt4, dt2}, 32'd3);

    // inc held high: one second per cycle, exactly one minute tick across 65 seconds.
    load = 1'b1;
    set_load(16'h2024, 5'h01, 6'h10, 6'h00, 7'h00, 7'h00, 3'd3);
    cycle();
    load = 1'b0; inc = 1'b1;
    mt_count = 0;
    for (int i = 0; i < 65; i++) begin
      cycle();
      if (mt2) mt_count++;
    end
    inc = 1'b0;
    chk("held.mticks", 32'(mt_count), 32'd1);
    chk("held.minsec", {16'b0, 1'b0, mi2, 1'b0, s2}, 32'h0000_0105);

    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 5))
        0: yy = 1999; 1: yy = 2000; 2: yy = 2099; 3: yy = 2100; 4: yy = 9999;
        default: yy = int'($urandom_range(0, 9999));
      endcase
      mo = int'($urandom_range(0, 13));
      dd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(26, 31));
      hh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : 23;
      mi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : 59;
      ss = int'($urandom_range(50, 60));
      dw = int'($urandom_range(0, 7));
      set_load(to_bcd(yy), 5'(to_bcd(mo)), 6'(to_bcd(dd)), 6'(to_bcd(hh)),
               7'(to_bcd(mi)), 7'(to_bcd(ss)), 3'(dw));
      if ($urandom_range(0, 9) == 0) ls[3:0] = 4'hB;
      if ($urandom_range(0, 19) == 0) ly[11:8] = 4'hC;
      load  = ($urandom_range(0, 9) == 0);
      inc   = ($urandom_range(0, 9) < 8);
      rst_n = ($urandom_range(0, 99) >= 2);
      cycle();
    end
    rst_n = 1'b1; load = 1'b0; inc = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
